dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data RAM between the CPU data port (master 0) and a secondary requester such as a debug/DMA engine (master 1). It sits between the masters and the word-addressed synchronous RAM, and owns the RAM address, write-data and write-enable lines. Each master gets a request/acknowledge handshake. Arbitration is round-robin by default, with fixed priority available as a build option.

---
 rtl/dmem_arbiter.sv | 82 ++++++++
 tb/tb_dmem_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master request/ack arbiter in front of a single-port synchronous data RAM.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  state_t state, next;
  logic win;
  logic lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic last;
`endif
  // winner selection and next-state sequencing
  always_comb begin
    win = m1_req & ~m0_req;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    win = (m0_req & m1_req) ? ~last : m1_req;
`endif
    next = state;
    next = state == IDLE    ? ((m0_req | m1_req) ? ISSUE : IDLE) :
           state == ISSUE   ? CAPTURE :
           state == CAPTURE ? ACK : IDLE;
  end
  // state, latched request, read-data capture and last-served pointer
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      state <= next;
      if (state == IDLE && (m0_req | m1_req)) begin
        grant     <= win;
        lat_we    <= win ? m1_we : m0_we;
        lat_addr  <= win ? m1_addr : m0_addr;
        lat_wdata <= win ? m1_wdata : m0_wdata;
      end
      if (state == CAPTURE && !lat_we && grant) m1_rdata <= ram_rdata;
      if (state == CAPTURE && !lat_we && !grant) m0_rdata <= ram_rdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      if (state == ACK) last <= grant;
`endif
    end
  end
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign ram_we    = (state == ISSUE) & lat_we;
  assign m0_ack    = (state == ACK) & ~grant;
  assign m1_ack    = (state == ACK) & grant;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with an expected-ack queue checked by an independent monitor.
module tb_dmem_arbiter;
  logic clock, resetn;
  logic m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [4:0] m0_addr, m1_addr, ram_addr;
  logic [31:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, ram_wdata, ram_rdata;
  logic ram_we, busy, grant;
  logic [31:0] mem [32];
  typedef struct {logic m; logic [31:0] r0; logic [31:0] r1;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, last_ack = 0;
  logic gap_chk = 0, have_prev = 0;

  dmem_arbiter #(.AW(5), .DW(32)) dut (
    .clock(clock), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .grant(grant)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // registered single-port RAM model
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every ack pops one expectation
  always @(negedge clock) begin
    if (m0_ack || m1_ack) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b expected none", m0_ack, m1_ack);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_ack", {30'd0, m1_ack, m0_ack}, e.m ? 32'd2 : 32'd1);
        chk("mon_m0_rdata", m0_rdata, e.r0);
        chk("mon_m1_rdata", m1_rdata, e.r1);
        chk("mon_ack_vs_we", {31'd0, ram_we}, 32'd0);
        if (gap_chk && have_prev) chk("mon_ack_gap", cyc - last_ack, 32'd4);
      end
      last_ack  = cyc;
      have_prev = 1;
    end
  end

  task automatic push(input logic m, input logic [31:0] r0, input logic [31:0] r1);
    exp_t e;
    e.m = m; e.r0 = r0; e.r1 = r1;
    q.push_back(e);
  endtask

  task automatic do_txn(input logic m, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [4:0] late_addr);
    @(posedge clock); #1;
    if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    @(negedge clock);
    chk("c0_busy", {31'd0, busy}, 32'd0);
    chk("c0_we", {31'd0, ram_we}, 32'd0);
    @(posedge clock); #1;
    m0_req = 0; m1_req = 0;
    if (m) m1_addr = late_addr; else m0_addr = late_addr;
    @(negedge clock);
    chk("c1_addr", {27'd0, ram_addr}, {27'd0, addr});
    chk("c1_we", {31'd0, ram_we}, {31'd0, we});
    chk("c1_grant", {31'd0, grant}, {31'd0, m});
    if (we) chk("c1_wdata", ram_wdata, wdata);
    @(negedge clock);
    chk("c2_we", {31'd0, ram_we}, 32'd0);
    chk("c2_addr", {27'd0, ram_addr}, {27'd0, addr});
    @(negedge clock);
    chk("c3_ack", {30'd0, m1_ack, m0_ack}, m ? 32'd2 : 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A50000 | i;
    mem[3] = 32'hDEADBEEF;
    resetn = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) @(posedge clock);
    #1 resetn = 1;
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", {27'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    // single read by m0
    push(0, 32'hDEADBEEF, 32'd0);
    do_txn(0, 0, 5'd3, 32'd0, 5'd3);
    // m1 write then read back
    push(1, 32'hDEADBEEF, 32'd0);
    do_txn(1, 1, 5'd7, 32'h12345678, 5'd7);
    push(1, 32'hDEADBEEF, 32'h12345678);
    do_txn(1, 0, 5'd7, 32'd0, 5'd7);
    // m0 drops req and changes address after being latched
    push(0, 32'hA5A50005, 32'h12345678);
    do_txn(0, 0, 5'd5, 32'd0, 5'd9);
    // reset asserted in CAPTURE aborts the transaction without ack
    @(posedge clock); #1;
    m1_req = 1; m1_we = 0; m1_addr = 5'd9;
    @(posedge clock); #1 m1_req = 0;
    @(posedge clock); #1 resetn = 0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("mid_rst_addr", {27'd0, ram_addr}, 32'd0);
    chk("mid_rst_m0_rdata", m0_rdata, 32'd0);
    chk("mid_rst_m1_rdata", m1_rdata, 32'd0);
    chk("mid_rst_grant", {31'd0, grant}, 32'd0);
    // contention: both requesting out of reset
    m0_req = 1; m0_we = 0; m0_addr = 5'd5;
    m1_req = 1; m1_we = 0; m1_addr = 5'd7;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    repeat (4) push(0, 32'hA5A50005, 32'd0);
`else
    push(0, 32'hA5A50005, 32'd0);
    push(1, 32'hA5A50005, 32'h12345678);
    push(0, 32'hA5A50005, 32'h12345678);
    push(1, 32'hA5A50005, 32'h12345678);
`endif
    have_prev = 0;
    gap_chk = 1;
    @(posedge clock); #1 resetn = 1;
    repeat (13) @(posedge clock);
    #1 m0_req = 0; m1_req = 0;
    repeat (6) @(negedge clock);
    gap_chk = 0;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
